// File: rtl/writeback_queue_pkg.sv
// Shared types for the writeback queue: unit codes, issue states and the
// packed entry stored per accepted writeback.
package writeback_queue_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;
    localparam int UNIT_W = 3;

    // Must track the dispatch unit codes.
    localparam logic [UNIT_W-1:0] FX_UNIT   = 3'd0;
    localparam logic [UNIT_W-1:0] LDST_UNIT = 3'd2;

    typedef enum logic {
        ISSUE_FIRST  = 1'b0,
        ISSUE_SECOND = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic [UNIT_W-1:0] unit;
        logic              en1;
        logic              en2;
        logic [REG_W-1:0]  addr1;
        logic [REG_W-1:0]  addr2;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
    } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Execution-side writeback inputs and register-file-side write ports.
interface writeback_queue_if #(
    parameter int regWidth  = 5,
    parameter int dataWidth = 64,
    parameter int depth     = 4
) ();
    localparam int OCC_W = $clog2(depth) + 1;

    logic [2:0]           functionalUnitCode_i;
    logic                 reg1WritebackEnable_i;
    logic                 reg2WritebackEnable_i;
    logic [regWidth-1:0]  reg1WritebackAddress_i;
    logic [regWidth-1:0]  reg2WritebackAddress_i;
    logic [dataWidth-1:0] reg1WritebackVal_i;
    logic [dataWidth-1:0] reg2WritebackVal_i;
    logic                 stall_o;
    logic [OCC_W-1:0]     occupancy_o;
    logic                 gprWriteEnable_o;
    logic [regWidth-1:0]  gprWriteAddress_o;
    logic [dataWidth-1:0] gprWriteVal_o;
    logic                 crXerWriteEnable_o;
    logic [regWidth-1:0]  crFieldBits_o;
    logic [dataWidth-1:0] xerWriteVal_o;

    modport slave (
        input  functionalUnitCode_i, reg1WritebackEnable_i, reg2WritebackEnable_i,
               reg1WritebackAddress_i, reg2WritebackAddress_i,
               reg1WritebackVal_i, reg2WritebackVal_i,
        output stall_o, occupancy_o, gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o,
               crXerWriteEnable_o, crFieldBits_o, xerWriteVal_o
    );

    modport master (
        output functionalUnitCode_i, reg1WritebackEnable_i, reg2WritebackEnable_i,
               reg1WritebackAddress_i, reg2WritebackAddress_i,
               reg1WritebackVal_i, reg2WritebackVal_i,
        input  stall_o, occupancy_o, gprWriteEnable_o, gprWriteAddress_o, gprWriteVal_o,
               crXerWriteEnable_o, crFieldBits_o, xerWriteVal_o
    );

endinterface

// File: rtl/writeback_entry_fifo.sv
// Circular entry store with wrap-around pointers and an occupancy count.
module writeback_entry_fifo
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  din,
    input  logic                       pop,
    output wb_entry_t                  dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers execution results and drains them through one GPR
// write port and one CR/XER port with a two-state issue FSM.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int                regWidth     = REG_W,
    parameter int                dataWidth    = DATA_W,
    parameter int                depth        = 4,
    parameter logic [UNIT_W-1:0] FXUnitCode   = FX_UNIT,
    parameter logic [UNIT_W-1:0] LdStUnitCode = LDST_UNIT
) (
    input logic             clock_i,
    input logic             reset_i,
    writeback_queue_if.slave wb
);
    localparam int OCC_W = $clog2(depth) + 1;

    generate
        if (depth < 2 || (depth & (depth - 1)) != 0 || FXUnitCode == LdStUnitCode ||
            regWidth != REG_W || dataWidth != DATA_W) begin : g_bad_cfg
            $error("writeback_queue: unsupported parameter set");
        end
    endgenerate

    wb_entry_t        in_entry;
    wb_entry_t        head;
    logic [OCC_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    issue_state_t     state, state_nxt;

    logic             gpr_we, gpr_we_nxt;
    logic [REG_W-1:0] gpr_addr, gpr_addr_nxt;
    logic [DATA_W-1:0] gpr_val, gpr_val_nxt;
    logic             cr_we, cr_we_nxt;
    logic [REG_W-1:0] cr_bits, cr_bits_nxt;
    logic [DATA_W-1:0] xer_val, xer_val_nxt;

    always_comb begin
        in_entry.unit  = wb.functionalUnitCode_i;
        in_entry.en1   = wb.reg1WritebackEnable_i;
        in_entry.en2   = wb.reg2WritebackEnable_i;
        in_entry.addr1 = wb.reg1WritebackAddress_i;
        in_entry.addr2 = wb.reg2WritebackAddress_i;
        in_entry.val1  = wb.reg1WritebackVal_i;
        in_entry.val2  = wb.reg2WritebackVal_i;
    end

    // stall comes from the registered count, so a same-edge pop never frees a slot.
    assign push = (in_entry.en1 || in_entry.en2) && !full;

    writeback_entry_fifo #(.DEPTH(depth)) u_fifo (
        .clk   (clock_i),
        .rst   (reset_i),
        .push  (push),
        .din   (in_entry),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        gpr_we_nxt   = 1'b0;
        gpr_addr_nxt = '0;
        gpr_val_nxt  = '0;
        cr_we_nxt    = 1'b0;
        cr_bits_nxt  = '0;
        xer_val_nxt  = '0;
        if (!empty) begin
            unique case (state)
                ISSUE_FIRST: begin
                    if (head.unit == FXUnitCode) begin
                        gpr_we_nxt = head.en1;
                        if (head.en1) begin
                            gpr_addr_nxt = head.addr1;
                            gpr_val_nxt  = head.val1;
                        end
                        cr_we_nxt = head.en2;
                        if (head.en2) begin
                            cr_bits_nxt = head.addr2;
                            xer_val_nxt = head.val2;
                        end
                        pop = 1'b1;
                    end else if (head.en1) begin
                        gpr_we_nxt   = 1'b1;
                        gpr_addr_nxt = head.addr1;
                        gpr_val_nxt  = head.val1;
                        if (head.en2) state_nxt = ISSUE_SECOND;
                        else          pop = 1'b1;
                    end else begin
                        gpr_we_nxt   = 1'b1;
                        gpr_addr_nxt = head.addr2;
                        gpr_val_nxt  = head.val2;
                        pop          = 1'b1;
                    end
                end
                ISSUE_SECOND: begin
                    gpr_we_nxt   = 1'b1;
                    gpr_addr_nxt = head.addr2;
                    gpr_val_nxt  = head.val2;
                    pop          = 1'b1;
                    state_nxt    = ISSUE_FIRST;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state    <= ISSUE_FIRST;
            gpr_we   <= 1'b0;
            gpr_addr <= '0;
            gpr_val  <= '0;
            cr_we    <= 1'b0;
            cr_bits  <= '0;
            xer_val  <= '0;
        end else begin
            state    <= state_nxt;
            gpr_we   <= gpr_we_nxt;
            gpr_addr <= gpr_addr_nxt;
            gpr_val  <= gpr_val_nxt;
            cr_we    <= cr_we_nxt;
            cr_bits  <= cr_bits_nxt;
            xer_val  <= xer_val_nxt;
        end
    end

    assign wb.stall_o            = full;
    assign wb.occupancy_o        = count;
    assign wb.gprWriteEnable_o   = gpr_we;
    assign wb.gprWriteAddress_o  = gpr_addr;
    assign wb.gprWriteVal_o      = gpr_val;
    assign wb.crXerWriteEnable_o = cr_we;
    assign wb.crFieldBits_o      = cr_bits;
    assign wb.xerWriteVal_o      = xer_val;

endmodule

// File: tb/tb_writeback_queue.sv
// Randomised scoreboard bench for writeback_queue: the driver queues expected
// port writes per accepted entry, a negedge monitor pops and compares them.
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_queue_if #(.regWidth(REG_W), .dataWidth(DATA_W), .depth(DEPTH)) wb ();

    writeback_queue #(.depth(DEPTH)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .wb      (wb)
    );

    typedef struct {
        logic              gw;
        logic [REG_W-1:0]  ga;
        logic [DATA_W-1:0] gv;
        logic              cw;
        logic [REG_W-1:0]  cb;
        logic [DATA_W-1:0] xv;
        bit                last;
    } ev_t;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  model_occ   = 0;
    int  pops;
    bit  model_enq   = 1'b0;
    bit  done        = 1'b0;
    ev_t got;

    // Reference: what each accepted entry must produce on the ports, in order.
    function automatic void model_push(input logic [2:0] u, input logic e1, input logic e2,
                                       input logic [REG_W-1:0] a1, input logic [REG_W-1:0] a2,
                                       input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
        ev_t e;
        e = '{gw: 1'b0, ga: '0, gv: '0, cw: 1'b0, cb: '0, xv: '0, last: 1'b1};
        if (u == FX_UNIT) begin
            e.gw = e1; e.ga = a1; e.gv = v1;
            e.cw = e2; e.cb = a2; e.xv = v2;
            exp_q.push_back(e);
        end else begin
            if (e1) begin
                e.gw = 1'b1; e.ga = a1; e.gv = v1; e.last = !e2;
                exp_q.push_back(e);
            end
            if (e2) begin
                e.gw = 1'b1; e.ga = a2; e.gv = v2; e.last = 1'b1;
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic drive(input logic [2:0] u, input logic e1, input logic e2,
                         input logic [REG_W-1:0] a1, input logic [REG_W-1:0] a2,
                         input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
        wb.functionalUnitCode_i   = u;
        wb.reg1WritebackEnable_i  = e1;
        wb.reg2WritebackEnable_i  = e2;
        wb.reg1WritebackAddress_i = a1;
        wb.reg2WritebackAddress_i = a2;
        wb.reg1WritebackVal_i     = v1;
        wb.reg2WritebackVal_i     = v2;
    endtask

    // Presents one result, holding it while stalled, for exactly one accepting edge.
    task automatic send(input logic [2:0] u, input logic e1, input logic e2,
                        input logic [REG_W-1:0] a1, input logic [REG_W-1:0] a2,
                        input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
        bit ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            #1;
            drive(u, e1, e2, a1, a2, v1, v2);
            if (!(e1 || e2)) begin
                model_enq = 1'b0;
                ok = 1'b1;
            end else if (!wb.stall_o) begin
                model_enq = 1'b1;
                model_push(u, e1, e2, a1, a2, v1, v2);
                ok = 1'b1;
            end else begin
                model_enq = 1'b0;
            end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: stall held for 200 cycles, required release");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            wb.reg1WritebackEnable_i = 1'b0;
            wb.reg2WritebackEnable_i = 1'b0;
            model_enq = 1'b0;
        end
    endtask

    task automatic check_zero(input string name);
        logic [2*REG_W+2*DATA_W+2+1+$clog2(DEPTH)+1-1:0] all;
        all = {wb.gprWriteEnable_o, wb.gprWriteAddress_o, wb.gprWriteVal_o,
               wb.crXerWriteEnable_o, wb.crFieldBits_o, wb.xerWriteVal_o,
               wb.stall_o, wb.occupancy_o};
        vectors++;
        if (all != '0) begin
            miscompares++;
            $display("FAIL %s: outputs %h, required all zero", name, all);
        end
    endtask

    // Reset asserted for one edge; the in-flight issue and all queued entries vanish.
    task automatic pulse_reset(input string name);
        #1;
        rst = 1'b1;
        wb.reg1WritebackEnable_i = 1'b0;
        wb.reg2WritebackEnable_i = 1'b0;
        model_enq = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_zero(name);
        model_occ = 0;
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && !done) begin
            pops = 0;
            if (wb.gprWriteEnable_o || wb.crXerWriteEnable_o) begin
                vectors++;
                got.gw = wb.gprWriteEnable_o;   got.ga = wb.gprWriteAddress_o; got.gv = wb.gprWriteVal_o;
                got.cw = wb.crXerWriteEnable_o; got.cb = wb.crFieldBits_o;     got.xv = wb.xerWriteVal_o;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: gpr %0b r%0d=%h cr %0b %0d xer %h, required no strobe",
                             got.gw, got.ga, got.gv, got.cw, got.cb, got.xv);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (got.gw != e.gw || got.cw != e.cw ||
                        (e.gw && (got.ga != e.ga || got.gv != e.gv)) ||
                        (e.cw && (got.cb != e.cb || got.xv != e.xv))) begin
                        miscompares++;
                        $display("FAIL write_port: got gpr %0b r%0d=%h cr %0b %0d xer %h, required gpr %0b r%0d=%h cr %0b %0d xer %h",
                                 got.gw, got.ga, got.gv, got.cw, got.cb, got.xv,
                                 e.gw, e.ga, e.gv, e.cw, e.cb, e.xv);
                    end
                    if (e.last) pops = 1;
                end
            end
            model_occ = model_occ + int'(model_enq) - pops;
            vectors++;
            if (int'(wb.occupancy_o) != model_occ || wb.stall_o != (model_occ == DEPTH)) begin
                miscompares++;
                $display("FAIL occupancy: occ %0d stall %0b, required occ %0d stall %0b",
                         wb.occupancy_o, wb.stall_o, model_occ, model_occ == DEPTH);
            end
        end
    end

    initial begin
        drive(3'd0, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        model_occ = 0;
        #1 rst = 1'b0;

        // FX: r3 plus CR bits 5 / XER 1 in a single cycle.
        send(FX_UNIT, 1'b1, 1'b1, 5'd3, 5'd5, 64'h10, 64'h1);
        idle(3);
        // Update-form load: r4 then r7.
        send(LDST_UNIT, 1'b1, 1'b1, 5'd4, 5'd7, 64'hAA, 64'h1000);
        idle(4);
        // Back-to-back dual writes fill the queue and exercise held inputs.
        for (int i = 0; i < 8; i++)
            send(LDST_UNIT, 1'b1, 1'b1, 5'(i), 5'(i + 16), 64'(32'hA000 + i), 64'(32'hB000 + i));
        idle(20);
        // Non-FX, reg2 only.
        send(3'd1, 1'b0, 1'b1, 5'd0, 5'd9, 64'hDEAD, 64'h55);
        idle(3);
        // Reset while the second entry is mid-issue with three queued.
        for (int i = 0; i < 4; i++)
            send(LDST_UNIT, 1'b1, 1'b1, 5'(i + 8), 5'(i + 24), 64'(i + 1), 64'(i + 100));
        @(negedge clk);
        pulse_reset("reset_mid_drain");
        send(FX_UNIT, 1'b1, 1'b1, 5'd12, 5'd3, 64'h1234, 64'h2);
        idle(3);
        // Both enables low: nothing stored, no strobes.
        for (int i = 0; i < 10; i++)
            send(3'($urandom_range(0, 7)), 1'b0, 1'b0, 5'($urandom), 5'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom});
        // Random mix of units, enable patterns and gaps.
        for (int i = 0; i < 400; i++) begin
            send(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 4));
        end
        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 200) begin
                idle(1);
                t++;
            end
        end
        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d writes outstanding, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
